latch_stage_generic: RTL and testbench
======================================

Name: latch_stage_generic

Overview:
- Parametrised pipeline-boundary register that replaces the per-stage hand-written latches (if/id, id/ex, ex/mem, mem/wb).
- Carries one opaque payload bus plus a valid bit, driven by the CPU-wide stall vector.
- Adds three things to the fixed latches: a flush input for exceptions and branch squash, an illegal-stall-pattern detector, and saturating per-stage bubble/hold performance counters.

Parameters:
- DATA_WIDTH, 32: payload width in bits (the concatenation of all stage fields).
- STALL_WIDTH, 6: width of the stall vector.
- STAGE, 3: index of this latch's own stall bit; this latch also reads stall[STAGE+1]. Legal range 0..STALL_WIDTH-2; elaboration error otherwise.
- NOP_PAYLOAD, {DATA_WIDTH{1'b0}}: payload value that represents a bubble (operator NOP, write enables disabled).
- COUNTER_WIDTH, 16: width of each performance counter.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  STALL_WIDTH  CPU stall vector; bit high = stall enable
- flush  input  1  squash this boundary; synchronous, active-high
- in_valid  input  1  upstream stage holds a real instruction
- in_payload  input  DATA_WIDTH  upstream stage fields
- out_valid  output  1  registered valid for the downstream stage
- out_payload  output  DATA_WIDTH  registered payload for the downstream stage
- counter_clear  input  1  synchronous clear of both counters
- bubble_count  output  COUNTER_WIDTH  cycles in which a bubble was inserted
- hold_count  output  COUNTER_WIDTH  cycles in which contents were held
- stall_error  output  1  sticky flag: illegal stall pattern seen

Behaviour:
- Definitions: s = stall[STAGE], n = stall[STAGE+1]. All state updates on the rising edge of clock; every output is registered.
- Per-edge action, strict priority:
  1. reset: out_valid=0, out_payload=NOP_PAYLOAD, bubble_count=0, hold_count=0, stall_error=0.
  2. flush: out_valid=0, out_payload=NOP_PAYLOAD. Overrides stall and in_valid. Counters unchanged.
  3. bubble (s=1, n=0): out_valid=0, out_payload=NOP_PAYLOAD. bubble_count +1.
  4. hold (s=1, n=1): out_valid and out_payload keep their values. hold_count +1.
  5. advance (s=0): out_valid=in_valid. out_payload=in_payload if in_valid=1, else NOP_PAYLOAD.
- Illegal pattern (s=0, n=1):
  - The stall vector must be monotonic, so this pattern is illegal.
  - The latch still performs advance.
  - stall_error sets to 1 and stays set until reset. It is not cleared by counter_clear or flush.
  - The pattern is not evaluated in a cycle where reset or flush wins.
- Latency: exactly 1 cycle from in_* to out_* on advance. No combinational path from any input to any output.
- Counters:
  - Unsigned and saturating at 2^COUNTER_WIDTH-1; they never wrap.
  - counter_clear beats a same-cycle increment: the counter becomes 0, not 1.
  - reset beats counter_clear.
- Hold after flush: the held content is the flushed bubble, so out_valid stays 0.
- Reset mid-hold: contents are discarded and reset values are applied next edge.
- Payload bits beyond the valid bit are never interpreted inside the block.

Decomposition:
- Shared package (cpu_defines) holds:
  - STALL_ENABLE/STALL_DISABLE, RESET_ENABLE and WRITE_DISABLE constants.
  - Per-boundary stage index constants (STAGE_IF_ID=1 ... STAGE_MEM_WB=4).
  - Per-boundary NOP payload constants built from OPERATOR_NOP.
- One natural sub-module: sat_counter. It is parametrised by width and has inc, clear and count ports, and is instantiated twice.
- Each stage wrapper packs its named fields into in_payload and unpacks out_payload.

Test Plan (DATA_WIDTH=32, STAGE=3, STALL_WIDTH=6, NOP_PAYLOAD=0, COUNTER_WIDTH=4):
1. Reset: assert reset with in_valid=1 and in_payload=0xDEADBEEF -> next edge out_valid=0, out_payload=0, both counts=0, stall_error=0.
2. Advance and hold:
   - stall=000000, in_valid=1, in_payload=0x11112222 -> out_payload=0x11112222 after 1 edge.
   - Then stall=011000 for 3 cycles while in_payload=0x33334444 -> out_payload stays 0x11112222 and hold_count=3.
3. Bubble and flush priority:
   - stall=001000 with in_payload=0x55556666 -> out_valid=0, out_payload=0, bubble_count=1.
   - Then flush=1 with stall=011000 -> out_valid=0 and hold_count unchanged.
4. Saturation and clear:
   - 20 consecutive bubble cycles -> bubble_count=15 and stays 15.
   - counter_clear=1 with stall=001000 -> bubble_count=0.
5. Illegal pattern: stall=010000, in_valid=1, in_payload=0x77778888 -> out_payload=0x77778888 and stall_error=1. The flag is still 1 after counter_clear and flush, and returns to 0 only on reset.
6. Invalid advance: stall=000000, in_valid=0, in_payload=0x9999AAAA -> out_valid=0 and out_payload=0.

Source files
------------

// File: rtl/latch_stage_generic_pkg.sv
// Shared CPU-wide constants for the pipeline boundary latches, plus the
// per-edge action decode used by latch_stage_generic.
package latch_stage_generic_pkg;

  localparam logic STALL_ENABLE  = 1'b1;
  localparam logic STALL_DISABLE = 1'b0;
  localparam logic RESET_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam int STAGE_IF_ID  = 1;
  localparam int STAGE_ID_EX  = 2;
  localparam int STAGE_EX_MEM = 3;
  localparam int STAGE_MEM_WB = 4;

  localparam logic [7:0] OPERATOR_NOP = 8'h00;

  // Bubble payloads: operator in the low byte, write enables cleared above it.
  localparam logic [31:0] NOP_IF_ID  = {24'h0, OPERATOR_NOP};
  localparam logic [31:0] NOP_ID_EX  = {{23{1'b0}}, WRITE_DISABLE, OPERATOR_NOP};
  localparam logic [31:0] NOP_EX_MEM = {{22{1'b0}}, WRITE_DISABLE, WRITE_DISABLE, OPERATOR_NOP};
  localparam logic [31:0] NOP_MEM_WB = {{23{1'b0}}, WRITE_DISABLE, OPERATOR_NOP};

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_ADVANCE
  } stage_action_e;

  function automatic stage_action_e decodeAction(input logic rst, input logic flush,
                                                 input logic s, input logic n);
    if (rst == RESET_ENABLE)                            return ACT_RESET;
    else if (flush)                                     return ACT_FLUSH;
    else if (s == STALL_ENABLE && n == STALL_DISABLE)   return ACT_BUBBLE;
    else if (s == STALL_ENABLE)                         return ACT_HOLD;
    else                                                return ACT_ADVANCE;
  endfunction

endpackage

// File: rtl/latch_stage_generic_sat_counter.sv
// Unsigned saturating event counter with synchronous reset and clear.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  import latch_stage_generic_pkg::*;

  logic [WIDTH-1:0] r_count;

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/latch_stage_generic.sv
// Generic pipeline boundary register: payload + valid, driven by the stall
// vector, with flush, illegal-stall detection and bubble/hold counters.
module latch_stage_generic
  import latch_stage_generic_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    STALL_WIDTH   = 6,
  parameter int                    STAGE         = 3,
  parameter logic [DATA_WIDTH-1:0] NOP_PAYLOAD   = {DATA_WIDTH{1'b0}},
  parameter int                    COUNTER_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [STALL_WIDTH-1:0]   stall,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_payload,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_payload,
  input  logic                     counter_clear,
  output logic [COUNTER_WIDTH-1:0] bubble_count,
  output logic [COUNTER_WIDTH-1:0] hold_count,
  output logic                     stall_error
);

  if (STAGE < 0 || STAGE > STALL_WIDTH - 2) begin : g_badStage
    $error("latch_stage_generic: STAGE must be in 0..STALL_WIDTH-2");
  end

  logic                  w_s;
  logic                  w_n;
  logic                  w_unusedStall;
  stage_action_e         w_action;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_payload;
  logic                  r_stallError;

  assign w_s           = stall[STAGE];
  assign w_n           = stall[STAGE+1];
  assign w_unusedStall = ^stall;
  assign w_action      = decodeAction(reset, flush, w_s, w_n);

  // Hold keeps whatever is registered, including a previously flushed bubble.
  always_ff @(posedge clock) begin
    case (w_action)
      ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
        r_valid   <= 1'b0;
        r_payload <= NOP_PAYLOAD;
      end
      ACT_HOLD: begin
        r_valid   <= r_valid;
        r_payload <= r_payload;
      end
      default: begin
        r_valid   <= in_valid;
        r_payload <= in_valid ? in_payload : NOP_PAYLOAD;
      end
    endcase
  end

  // Sticky until reset; a monotonic stall vector never has s=0 with n=1.
  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE) begin
      r_stallError <= 1'b0;
    end else if (!flush && (w_s == STALL_DISABLE) && (w_n == STALL_ENABLE)) begin
      r_stallError <= 1'b1;
    end
  end

  sat_counter #(.WIDTH(COUNTER_WIDTH)) u_bubbleCounter (
    .clock (clock),
    .reset (reset),
    .clear (counter_clear),
    .inc   (w_action == ACT_BUBBLE),
    .count (bubble_count)
  );

  sat_counter #(.WIDTH(COUNTER_WIDTH)) u_holdCounter (
    .clock (clock),
    .reset (reset),
    .clear (counter_clear),
    .inc   (w_action == ACT_HOLD),
    .count (hold_count)
  );

  assign out_valid   = r_valid;
  assign out_payload = r_payload;
  assign stall_error = r_stallError;

endmodule

// File: tb/tb_latch_stage_generic.sv
// Scoreboard bench for latch_stage_generic: a reference model pushes the
// expected post-edge state for every driven cycle, which is popped and checked.
module tb_latch_stage_generic;

  localparam int DW = 32;
  localparam int SW = 6;
  localparam int ST = 3;
  localparam int CW = 4;

  typedef struct {
    logic          valid;
    logic [DW-1:0] payload;
    logic [CW-1:0] bubbles;
    logic [CW-1:0] holds;
    logic          err;
  } expect_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [SW-1:0] stall = '0;
  logic          flush = 1'b0;
  logic          inValid = 1'b0;
  logic [DW-1:0] inPayload = '0;
  logic          outValid;
  logic [DW-1:0] outPayload;
  logic          counterClear = 1'b0;
  logic [CW-1:0] bubbleCount;
  logic [CW-1:0] holdCount;
  logic          stallError;

  int testsRun = 0;
  int testsFailed = 0;

  expect_t scoreboard[$];
  expect_t model;

  always #5 clock = ~clock;

  latch_stage_generic #(
    .DATA_WIDTH    (DW),
    .STALL_WIDTH   (SW),
    .STAGE         (ST),
    .NOP_PAYLOAD   ('0),
    .COUNTER_WIDTH (CW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .in_valid      (inValid),
    .in_payload    (inPayload),
    .out_valid     (outValid),
    .out_payload   (outPayload),
    .counter_clear (counterClear),
    .bubble_count  (bubbleCount),
    .hold_count    (holdCount),
    .stall_error   (stallError)
  );

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model of one clock edge, written from the behavioural rules.
  function automatic expect_t nextModel(input expect_t cur, input logic rst,
                                        input logic [SW-1:0] stl, input logic fl,
                                        input logic v, input logic [DW-1:0] p,
                                        input logic clr);
    expect_t nx = cur;
    logic s = stl[ST];
    logic n = stl[ST+1];
    if (rst) begin
      nx = '{1'b0, '0, '0, '0, 1'b0};
      return nx;
    end
    if (!fl && !s && n) nx.err = 1'b1;
    if (fl) begin
      nx.valid = 1'b0; nx.payload = '0;
    end else if (s && !n) begin
      nx.valid = 1'b0; nx.payload = '0;
      if (cur.bubbles != 4'hF) nx.bubbles = cur.bubbles + 1'b1;
    end else if (s && n) begin
      if (cur.holds != 4'hF) nx.holds = cur.holds + 1'b1;
    end else begin
      nx.valid = v; nx.payload = v ? p : '0;
    end
    if (clr) begin
      nx.bubbles = '0; nx.holds = '0;
    end
    return nx;
  endfunction

  task automatic applyStimulus(input logic rst, input logic [SW-1:0] stl,
                               input logic fl, input logic v,
                               input logic [DW-1:0] p, input logic clr);
    expect_t exp;
    @(negedge clock);
    reset = rst; stall = stl; flush = fl; inValid = v; inPayload = p; counterClear = clr;
    model = nextModel(model, rst, stl, fl, v, p, clr);
    scoreboard.push_back(model);
    @(posedge clock);
    #1;
    if (scoreboard.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      exp = scoreboard.pop_front();
      checkOutput("out_valid", {31'd0, outValid}, {31'd0, exp.valid});
      checkOutput("out_payload", outPayload, exp.payload);
      checkOutput("bubble_count", {28'd0, bubbleCount}, {28'd0, exp.bubbles});
      checkOutput("hold_count", {28'd0, holdCount}, {28'd0, exp.holds});
      checkOutput("stall_error", {31'd0, stallError}, {31'd0, exp.err});
    end
  endtask

  initial begin
    model = '{1'b0, '0, '0, '0, 1'b0};

    applyStimulus(1'b1, 6'b000000, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    checkOutput("reset_valid", {31'd0, outValid}, 32'd0);
    checkOutput("reset_payload", outPayload, 32'd0);

    applyStimulus(1'b0, 6'b000000, 1'b0, 1'b1, 32'h11112222, 1'b0);
    checkOutput("advance_payload", outPayload, 32'h11112222);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 6'b011000, 1'b0, 1'b1, 32'h33334444, 1'b0);
    checkOutput("hold_payload", outPayload, 32'h11112222);
    checkOutput("hold_count3", {28'd0, holdCount}, 32'd3);

    applyStimulus(1'b0, 6'b001000, 1'b0, 1'b1, 32'h55556666, 1'b0);
    checkOutput("bubble_count1", {28'd0, bubbleCount}, 32'd1);
    applyStimulus(1'b0, 6'b011000, 1'b1, 1'b1, 32'h55556666, 1'b0);
    checkOutput("flush_hold_count", {28'd0, holdCount}, 32'd3);
    applyStimulus(1'b0, 6'b011000, 1'b0, 1'b1, 32'h12345678, 1'b0);
    checkOutput("hold_after_flush_valid", {31'd0, outValid}, 32'd0);

    for (int i = 0; i < 20; i++)
      applyStimulus(1'b0, 6'b001000, 1'b0, 1'b1, 32'hABCD0000 + i, 1'b0);
    checkOutput("bubble_saturated", {28'd0, bubbleCount}, 32'd15);
    applyStimulus(1'b0, 6'b001000, 1'b0, 1'b1, 32'h0, 1'b1);
    checkOutput("clear_beats_inc", {28'd0, bubbleCount}, 32'd0);

    applyStimulus(1'b0, 6'b010000, 1'b0, 1'b1, 32'h77778888, 1'b0);
    checkOutput("illegal_payload", outPayload, 32'h77778888);
    checkOutput("illegal_flag", {31'd0, stallError}, 32'd1);
    applyStimulus(1'b0, 6'b000000, 1'b0, 1'b1, 32'h1, 1'b1);
    applyStimulus(1'b0, 6'b000000, 1'b1, 1'b1, 32'h2, 1'b0);
    checkOutput("flag_sticky", {31'd0, stallError}, 32'd1);

    applyStimulus(1'b0, 6'b000000, 1'b0, 1'b0, 32'h9999AAAA, 1'b0);
    checkOutput("invalid_adv_valid", {31'd0, outValid}, 32'd0);
    checkOutput("invalid_adv_payload", outPayload, 32'd0);

    applyStimulus(1'b0, 6'b010000, 1'b1, 1'b1, 32'h5, 1'b0);
    applyStimulus(1'b0, 6'b011000, 1'b0, 1'b1, 32'h6, 1'b0);
    applyStimulus(1'b1, 6'b011000, 1'b0, 1'b1, 32'h7, 1'b0);
    checkOutput("reset_clears_flag", {31'd0, stallError}, 32'd0);
    checkOutput("reset_mid_hold_count", {28'd0, holdCount}, 32'd0);

    applyStimulus(1'b0, 6'b010000, 1'b1, 1'b1, 32'h8, 1'b0);
    checkOutput("flush_masks_illegal", {31'd0, stallError}, 32'd0);

    for (int i = 0; i < 60; i++)
      applyStimulus($urandom_range(0, 19) == 0, 6'($urandom), $urandom_range(0, 7) == 0,
                    1'($urandom), 32'($urandom), $urandom_range(0, 9) == 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
